// File: rtl/l2_bank_arbiter.sv
// Round-robin arbiter multiplexing NB_MASTERS TCDM requesters onto a single L2 bank port.
// Define L2_BANK_ARB_PERF_CNT_EN to add the conflict-cycle counter (clr_cnt_i / conflict_cnt_o).
module l2_bank_arbiter #(
  parameter int NB_MASTERS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,

  input  logic [NB_MASTERS-1:0]                   m_req_i,
  input  logic [NB_MASTERS-1:0]                   m_wen_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0]   m_add_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
  output logic [NB_MASTERS-1:0]                   m_gnt_o,
  output logic [NB_MASTERS-1:0]                   m_r_valid_o,
  output logic [DATA_WIDTH-1:0]                   m_r_rdata_o,

  output logic                                    s_req_o,
  output logic [ADDR_WIDTH-1:0]                   s_add_o,
  output logic                                    s_wen_o,
  output logic [DATA_WIDTH-1:0]                   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                 s_be_o,
  input  logic                                    s_gnt_i,
  input  logic                                    s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                   s_r_rdata_i
`ifdef L2_BANK_ARB_PERF_CNT_EN
  ,
  input  logic                                    clr_cnt_i,
  output logic [31:0]                             conflict_cnt_o
`endif
);

  localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_next;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] resp_idx;
  logic             resp_pend;
  logic             any_req;
  logic             accept;

  assign any_req = |m_req_i;
  assign accept  = any_req & s_gnt_i;

  // Scan from rr_ptr upwards with wrap; the first requester found wins.
  always_comb begin
    logic [IDX_W:0] cand;
    logic           found;
    // NOTE: every variable written here gets a default first, so no path can leave a latch behind.
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NB_MASTERS)) begin
        cand = cand - (IDX_W+1)'(NB_MASTERS);
      end
      if (!found && m_req_i[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (accept) begin
      rr_ptr_next = (winner == IDX_W'(NB_MASTERS-1)) ? '0 : winner + 1'b1;
    end
  end

  // Bank-side request is a pure mux of the winner; zeroed when idle.
  always_comb begin
    s_req_o   = any_req;
    s_add_o   = '0;
    s_wen_o   = 1'b0;
    s_wdata_o = '0;
    s_be_o    = '0;
    m_gnt_o   = '0;
    if (any_req) begin
      s_add_o          = m_add_i[winner];
      s_wen_o          = m_wen_i[winner];
      s_wdata_o        = m_wdata_i[winner];
      s_be_o           = m_be_i[winner];
      m_gnt_o[winner]  = s_gnt_i;
    end
  end

  always_comb begin
    m_r_valid_o = '0;
    if (resp_pend && s_r_valid_i) begin
      m_r_valid_o[resp_idx] = 1'b1;
    end
  end

  assign m_r_rdata_o = s_r_rdata_i;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr    <= '0;
      resp_idx  <= '0;
      resp_pend <= 1'b0;
    end else begin
      rr_ptr    <= rr_ptr_next;
      resp_pend <= accept;
      if (accept) begin
        resp_idx <= winner;
      end
    end
  end

`ifdef L2_BANK_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt;
  logic        conflict;

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign conflict = |(m_req_i & (m_req_i - NB_MASTERS'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt <= '0;
    end else if (clr_cnt_i) begin
      conflict_cnt <= '0;
    end else if (conflict && conflict_cnt != 32'hFFFF_FFFF) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt;
`endif

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Directed self-checking bench for l2_bank_arbiter; counter checks run when
// L2_BANK_ARB_PERF_CNT_EN is defined.
module tb_l2_bank_arbiter;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                    clk;
  logic                    rst_n;
  logic [NB-1:0]           m_req;
  logic [NB-1:0]           m_wen;
  logic [NB-1:0][AW-1:0]   m_add;
  logic [NB-1:0][DW-1:0]   m_wdata;
  logic [NB-1:0][DW/8-1:0] m_be;
  logic [NB-1:0]           m_gnt;
  logic [NB-1:0]           m_r_valid;
  logic [DW-1:0]           m_r_rdata;
  logic                    s_req;
  logic [AW-1:0]           s_add;
  logic                    s_wen;
  logic [DW-1:0]           s_wdata;
  logic [DW/8-1:0]         s_be;
  logic                    s_gnt;
  logic                    s_r_valid;
  logic [DW-1:0]           s_r_rdata;
`ifdef L2_BANK_ARB_PERF_CNT_EN
  logic                    clr_cnt;
  logic [31:0]             conflict_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  l2_bank_arbiter #(.NB_MASTERS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .m_req_i        (m_req),
    .m_wen_i        (m_wen),
    .m_add_i        (m_add),
    .m_wdata_i      (m_wdata),
    .m_be_i         (m_be),
    .m_gnt_o        (m_gnt),
    .m_r_valid_o    (m_r_valid),
    .m_r_rdata_o    (m_r_rdata),
    .s_req_o        (s_req),
    .s_add_o        (s_add),
    .s_wen_o        (s_wen),
    .s_wdata_o      (s_wdata),
    .s_be_o         (s_be),
    .s_gnt_i        (s_gnt),
    .s_r_valid_i    (s_r_valid),
    .s_r_rdata_i    (s_r_rdata)
`ifdef L2_BANK_ARB_PERF_CNT_EN
    ,
    .clr_cnt_i      (clr_cnt),
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    m_req     = '0;
    m_wen     = '1;
    m_add     = '0;
    m_wdata   = '0;
    m_be      = '0;
    s_gnt     = 1'b0;
    s_r_valid = 1'b1;
    s_r_rdata = 32'h1234_5678;
`ifdef L2_BANK_ARB_PERF_CNT_EN
    clr_cnt   = 1'b0;
`endif
    for (int i = 0; i < NB; i++) m_add[i] = 32'h1000_0000 + 32'(i * 4);

    // Reset: response valid suppressed, combinational path live with rr_ptr=0.
    step(); #1;
    check("rst_rvalid", 32'(m_r_valid), 32'h0);
    check("rst_sreq_idle", 32'(s_req), 32'h0);
    check("rst_sadd_idle", s_add, 32'h0);
    check("rst_rdata", m_r_rdata, 32'h1234_5678);
    m_req = 4'b0011; s_gnt = 1'b1; #1;
    check("rst_sreq", 32'(s_req), 32'h1);
    check("rst_gnt", 32'(m_gnt), 32'h1);
    check("rst_sadd", s_add, 32'h1000_0000);

    step(); rst_n = 1'b1; m_req = '0; #1;
    check("post_rst_rvalid", 32'(m_r_valid), 32'h0);

    // Round-robin over all four masters, responses one cycle behind grants.
    for (int k = 0; k < 8; k++) begin
      step(); m_req = 4'b1111; s_gnt = 1'b1; s_r_valid = 1'b1; #1;
      check($sformatf("rr_gnt_%0d", k), 32'(m_gnt), 32'(1) << (k % 4));
      check($sformatf("rr_sadd_%0d", k), s_add, 32'h1000_0000 + 32'((k % 4) * 4));
      check($sformatf("rr_rvalid_%0d", k), 32'(m_r_valid),
            (k == 0) ? 32'h0 : (32'(1) << ((k - 1) % 4)));
    end
    step(); m_req = '0; #1;
    check("rr_last_rvalid", 32'(m_r_valid), 32'h8);
    check("idle_sreq", 32'(s_req), 32'h0);
    check("idle_gnt", 32'(m_gnt), 32'h0);
    step(); #1;
    check("no_pend_rvalid", 32'(m_r_valid), 32'h0);

    // Bank stall with masters 0 and 2 requesting.
    for (int k = 0; k < 3; k++) begin
      step(); m_req = 4'b0101; s_gnt = 1'b0; s_r_valid = 1'b1; #1;
      check($sformatf("stall_gnt_%0d", k), 32'(m_gnt), 32'h0);
      check($sformatf("stall_rvalid_%0d", k), 32'(m_r_valid), 32'h0);
      check($sformatf("stall_sreq_%0d", k), 32'(s_req), 32'h1);
    end
    step(); s_gnt = 1'b1; #1;
    check("stall_rel_gnt0", 32'(m_gnt), 32'h1);
    step(); #1;
    check("stall_rel_gnt2", 32'(m_gnt), 32'h4);
    check("stall_rel_rv0", 32'(m_r_valid), 32'h1);
    step(); m_req = '0; #1;
    check("stall_rel_rv2", 32'(m_r_valid), 32'h4);

    // Master 2 writes, then master 0 reads the same word.
    step();
    m_req = 4'b0100; m_wen = 4'b1011;
    m_add[2] = 32'h1C01_0008; m_wdata[2] = 32'hDEAD_BEEF; m_be[2] = 4'hF;
    s_gnt = 1'b1; s_r_valid = 1'b0; #1;
    check("wr_gnt", 32'(m_gnt), 32'h4);
    check("wr_sadd", s_add, 32'h1C01_0008);
    check("wr_swen", 32'(s_wen), 32'h0);
    check("wr_swdata", s_wdata, 32'hDEAD_BEEF);
    check("wr_sbe", 32'(s_be), 32'hF);
    step();
    m_req = 4'b0001; m_wen = 4'b1111; m_add[0] = 32'h1C01_0008;
    s_r_valid = 1'b1; s_r_rdata = 32'h0; #1;
    check("rd_gnt", 32'(m_gnt), 32'h1);
    check("rd_sadd", s_add, 32'h1C01_0008);
    check("rd_swen", 32'(s_wen), 32'h1);
    check("wr_rvalid", 32'(m_r_valid), 32'h4);
    step(); m_req = '0; s_r_rdata = 32'hDEAD_BEEF; #1;
    check("rd_rvalid", 32'(m_r_valid), 32'h1);
    check("rd_rdata", m_r_rdata, 32'hDEAD_BEEF);
    check("rd_idle_sadd", s_add, 32'h0);

    // rr_ptr is now 1: grant master 1, then reset with its response in flight.
    step(); m_req = 4'b1111; s_r_valid = 1'b0; #1;
    check("pre_rst_gnt", 32'(m_gnt), 32'h2);
    step(); rst_n = 1'b0; m_req = '0; s_r_valid = 1'b1; #1;
    check("inflight_rst_rvalid", 32'(m_r_valid), 32'h0);
    step(); rst_n = 1'b1; #1;
    check("after_rst_rvalid", 32'(m_r_valid), 32'h0);
    step(); m_req = 4'b1111; #1;
    check("after_rst_ptr0", 32'(m_gnt), 32'h1);
    check("after_rst_rv_none", 32'(m_r_valid), 32'h0);

    // rr_ptr is 1: stall picks master 2; it drops and master 3 is served.
    step(); m_req = 4'b1100; s_gnt = 1'b0; #1;
    check("drop_stall_sadd", s_add, 32'h1C01_0008);
    step(); m_req = 4'b1000; s_gnt = 1'b1; #1;
    check("drop_gnt3", 32'(m_gnt), 32'h8);
    check("drop_sadd3", s_add, 32'h1000_000C);

`ifdef L2_BANK_ARB_PERF_CNT_EN
    step(); m_req = '0; clr_cnt = 1'b1;
    step(); clr_cnt = 1'b0; #1;
    check("cnt_clr0", conflict_cnt, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(); m_req = 4'b0011;
    end
    step(); m_req = 4'b0100; #1;
    check("cnt_5", conflict_cnt, 32'd5);
    step(); #1;
    check("cnt_single_hold", conflict_cnt, 32'd5);
    m_req = 4'b0011; clr_cnt = 1'b1;
    step(); clr_cnt = 1'b0; m_req = '0; #1;
    check("cnt_clear_wins", conflict_cnt, 32'h0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
